// File: rtl/cpu_pkg.sv
// Shared datapath constants and types for the CPU register file and its read ports.
package cpu_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/reg_read_port.sv
// One combinational read port. It performs the index decode and forces register 0 to read as zero.
// Build with REGFILE_BYPASS_EN defined to add same-cycle write-through forwarding.
module reg_read_port #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic [ADDR_W-1:0]             rd_addr,
    input  logic [DEPTH-1:0][DATA_W-1:0]  regs,
`ifdef REGFILE_BYPASS_EN
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
`endif
    output logic [DATA_W-1:0]             rd_data
);
    import cpu_pkg::*;

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    always_comb begin
        rd_data = '0;
        if (rd_addr != ZERO_IDX) begin
            rd_data = regs[rd_addr];
        end
`ifdef REGFILE_BYPASS_EN
        // Forward the incoming write so a reader sees it before the edge commits it.
        if (rst_n && wr_en && (wr_addr != ZERO_IDX) && (rd_addr == wr_addr)) begin
            rd_data = wr_data;
        end
`endif
    end

endmodule

// File: rtl/reg_file.sv
// Register file with two read ports and one write port. Register 0 is hardwired to zero.
// Defining REGFILE_BYPASS_EN enables write-through forwarding in both read ports.
module reg_file #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);
    import cpu_pkg::*;

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    // Only registers 1..DEPTH-1 hold state; index 0 is never stored.
    logic [DATA_W-1:0]            stor [1:DEPTH-1];
    logic [DEPTH-1:0][DATA_W-1:0] regs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < DEPTH; i++) begin
                stor[i] <= '0;
            end
        end else if (wr_en && (wr_addr != ZERO_IDX)) begin
            stor[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        regs = '0;
        for (int i = 1; i < DEPTH; i++) begin
            regs[i] = stor[i];
        end
    end

    reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_port_a (
        .rd_addr (rd_addr_a),
        .regs    (regs),
`ifdef REGFILE_BYPASS_EN
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
`endif
        .rd_data (rd_data_a)
    );

    reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_port_b (
        .rd_addr (rd_addr_b),
        .regs    (regs),
`ifdef REGFILE_BYPASS_EN
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
`endif
        .rd_data (rd_data_b)
    );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios followed by random traffic against an array model.
module tb_reg_file;
    import cpu_pkg::*;

    logic     clk = 1'b0;
    logic     rst_n;
    reg_idx_t rd_addr_a, rd_addr_b, wr_addr;
    word_t    rd_data_a, rd_data_b, wr_data;
    logic     wr_en;

    word_t model [8];
    int    n_cmp = 0;
    int    n_err = 0;

    always #5 clk = ~clk;

    reg_file dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    function automatic word_t exp_read(reg_idx_t a);
        word_t v;
        v = (a == 3'd0) ? 8'h00 : model[a];
`ifdef REGFILE_BYPASS_EN
        if (rst_n && wr_en && wr_addr != 3'd0 && a == wr_addr) v = wr_data;
`endif
        if (!rst_n) v = 8'h00;
        return v;
    endfunction

    task automatic check(input string tag, input word_t obs, input word_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_ports(input string tag);
        check({tag, "_a"}, rd_data_a, exp_read(rd_addr_a));
        check({tag, "_b"}, rd_data_b, exp_read(rd_addr_b));
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
    endtask

    // One clock cycle: drive at negedge, check before the edge, commit the model, check after it.
    task automatic cycle(input logic en, input reg_idx_t wa, input word_t wd,
                         input reg_idx_t ra, input reg_idx_t rb, input string tag);
        @(negedge clk);
        wr_en = en; wr_addr = wa; wr_data = wd; rd_addr_a = ra; rd_addr_b = rb;
        #2 check_ports({tag, "_pre"});
        @(posedge clk);
        if (rst_n && en && wa != 3'd0) model[wa] = wd;
        #1 check_ports({tag, "_post"});
    endtask

    initial begin
        word_t exp_raw;
        model_clear();
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;

        // Reset: sweep every index on both ports while held in reset, with a write attempt pending.
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'hEE;
        for (int a = 0; a < 8; a++) begin
            rd_addr_a = reg_idx_t'(a); rd_addr_b = reg_idx_t'(7 - a);
            #3;
            check("rst_sweep_a", rd_data_a, 8'h00);
            check("rst_sweep_b", rd_data_b, 8'h00);
        end
        wr_en = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        cycle(1'b0, 3'd0, 8'h00, 3'd4, 3'd1, "idle_after_rst");
        check("rst_reg4_a", rd_data_a, 8'h00);

        // Write 0x11*i to register i, then read every register back on both ports.
        for (int i = 1; i < 8; i++)
            cycle(1'b1, reg_idx_t'(i), word_t'(8'h11 * i), 3'd0, reg_idx_t'(i), "wr_each");
        for (int a = 0; a < 8; a++) begin
            cycle(1'b0, 3'd0, 8'h00, reg_idx_t'(a), reg_idx_t'(a), "rd_each");
            check("rd_each_lit_a", rd_data_a, word_t'(8'h11 * a));
            check("rd_each_lit_b", rd_data_b, word_t'(8'h11 * a));
        end

        // Writes to register 0 are discarded.
        cycle(1'b1, 3'd0, 8'hFF, 3'd0, 3'd0, "zero_wr");
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 3'd0, 8'h00, 3'd0, 3'd1, "zero_hold");
            check("zero_lit_a", rd_data_a, 8'h00);
        end

        // Same-cycle read-after-write on register 3.
        cycle(1'b1, 3'd3, 8'h5A, 3'd0, 3'd0, "raw_setup");
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5; rd_addr_a = 3'd3; rd_addr_b = 3'd3;
`ifdef REGFILE_BYPASS_EN
        exp_raw = 8'hA5;
`else
        exp_raw = 8'h5A;
`endif
        #2 check("raw_before_edge", rd_data_a, exp_raw);
        @(posedge clk); model[3] = 8'hA5;
        #1 check("raw_after_edge", rd_data_a, 8'hA5);
        cycle(1'b0, 3'd0, 8'h00, 3'd3, 3'd3, "raw_settle");

        // Asynchronous reset between edges, with a write attempted while held.
        cycle(1'b1, 3'd2, 8'h3C, 3'd0, 3'd2, "async_setup");
        @(negedge clk);
        wr_en = 1'b0; rd_addr_b = 3'd2;
        #1 check("async_pre", rd_data_b, 8'h3C);
        rst_n = 1'b0; model_clear();
        #1 check("async_drop", rd_data_b, 8'h00);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h77;
        @(posedge clk);
        #1 check("async_held", rd_data_b, 8'h00);
        @(negedge clk); wr_en = 1'b0; rst_n = 1'b1;
        #1 check("async_release", rd_data_b, 8'h00);
        cycle(1'b0, 3'd0, 8'h00, 3'd2, 3'd2, "async_after");

        // Dual-port independence while an unrelated register is written.
        cycle(1'b1, 3'd5, 8'h01, 3'd0, 3'd0, "dual_w5");
        cycle(1'b1, 3'd6, 8'h80, 3'd0, 3'd0, "dual_w6");
        cycle(1'b1, 3'd7, 8'h7F, 3'd5, 3'd6, "dual_rd");
        check("dual_lit_a", rd_data_a, 8'h01);
        check("dual_lit_b", rd_data_b, 8'h80);
        cycle(1'b0, 3'd0, 8'h00, 3'd7, 3'd6, "dual_r7");
        check("dual_lit_r7", rd_data_a, 8'h7F);

        // Random traffic against the array model.
        for (int n = 0; n < 300; n++) begin
            cycle(1'($urandom_range(0, 1)), reg_idx_t'($urandom_range(0, 7)),
                  word_t'($urandom), reg_idx_t'($urandom_range(0, 7)),
                  reg_idx_t'($urandom_range(0, 7)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
